// File: rtl/ascon_bdi_formatter.sv
// ascon_bdi_formatter: byte-granular segment stream to Ascon key/bdi words with 10* padding
// Optional sticky protocol checker on port err when ASCON_FMT_ERR_EN is defined.
module ascon_bdi_formatter #(
  parameter int CCW  = 32,
  parameter int CCSW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CCW-1:0]  s_data,
  input  logic [3:0]      s_keep,
  input  logic [3:0]      s_type,
  input  logic            s_last,
  input  logic            s_eoi,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [CCSW-1:0] key,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [CCW-1:0]  bdi,
  output logic [3:0]      bdi_type,
  output logic            bdi_eot,
  output logic            bdi_eoi,
  output logic            bdi_valid,
  input  logic            bdi_ready
`ifdef ASCON_FMT_ERR_EN
  ,
  output logic            err
`endif
);
  localparam logic [3:0] D_NULL = 4'h0, D_AD = 4'h1, D_MSG = 4'h4, D_KEY = 4'hC;
  typedef enum logic [1:0] {IDLE, PASS, PAD, DROP} state_t;
  state_t state_q;
  logic [3:0] typ_q, typ;
  logic eoi_q, acc, padt;
  logic [CCW-1:0] m, fm, padw;
  assign typ = (state_q == PASS || state_q == PAD) ? typ_q : s_type;
  assign padt = typ == D_AD || typ == D_MSG;
  assign s_ready = rst & (state_q != PAD) & ((typ == D_KEY) ? (!key_valid | key_ready) : (!bdi_valid | bdi_ready));
  assign acc = s_valid & s_ready;
  // fm marks the first invalid byte lane: invalid here, valid (or none) above it
  assign m = {{8{s_keep[3]}}, {8{s_keep[2]}}, {8{s_keep[1]}}, {8{s_keep[0]}}};
  assign fm = ~m & ~(~m >> 8);
  assign padw = (s_data & m) | (fm & {4{8'h80}});
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      typ_q     <= D_NULL;
      eoi_q     <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
      bdi       <= '0;
      bdi_type  <= D_NULL;
      bdi_eot   <= 1'b0;
      bdi_eoi   <= 1'b0;
      bdi_valid <= 1'b0;
    end else begin
      if (key_ready) key_valid <= 1'b0;
      if (bdi_ready) bdi_valid <= 1'b0;
      if (state_q == DROP) state_q <= IDLE;
      if (state_q == PAD && (!bdi_valid || bdi_ready)) begin
        bdi       <= {8'h80, {(CCW-8){1'b0}}};
        bdi_type  <= typ_q;
        bdi_eot   <= 1'b1;
        bdi_eoi   <= eoi_q;
        bdi_valid <= 1'b1;
        state_q   <= IDLE;
      end
      if (acc) begin
        typ_q   <= typ;
        state_q <= s_last ? IDLE : PASS;
        if (typ == D_KEY) begin
          key       <= s_data;
          key_valid <= 1'b1;
        end else if (!padt) begin
          bdi       <= s_data;
          bdi_type  <= typ;
          bdi_eot   <= s_last;
          bdi_eoi   <= s_last & s_eoi;
          bdi_valid <= 1'b1;
        end else if (!s_last || s_keep == 4'hF) begin
          bdi       <= s_data;
          bdi_type  <= typ;
          bdi_eot   <= 1'b0;
          bdi_eoi   <= 1'b0;
          bdi_valid <= 1'b1;
          if (s_last) begin
            state_q <= PAD;
            eoi_q   <= s_eoi;
          end
        end else if (s_keep != 4'h0) begin
          bdi       <= padw;
          bdi_type  <= typ;
          bdi_eot   <= 1'b1;
          bdi_eoi   <= s_eoi;
          bdi_valid <= 1'b1;
        end else if (typ == D_AD) begin
          state_q <= DROP;
        end
      end
    end
  end
`ifdef ASCON_FMT_ERR_EN
  localparam logic [3:0] D_TAG = 4'h8, D_NONCE = 4'hD;
  logic bad;
  assign bad = acc & (!(s_keep inside {4'h0, 4'h8, 4'hC, 4'hE, 4'hF})
             | (s_keep != 4'hF & !s_last)
             | (state_q == PASS & s_type != typ_q)
             | ((typ == D_KEY | typ == D_NONCE | typ == D_TAG) & s_keep != 4'hF));
  always_ff @(posedge clk) err <= !rst ? 1'b0 : (err | bad);
`endif
endmodule

// File: tb/tb_ascon_bdi_formatter.sv
// tb_ascon_bdi_formatter: scoreboard bench; expected words come from a byte-level padding model
module tb_ascon_bdi_formatter;
  localparam logic [3:0] D_NULL = 4'h0, D_AD = 4'h1, D_MSG = 4'h4, D_TAG = 4'h8, D_KEY = 4'hC, D_NONCE = 4'hD;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0] s_keep = '0, s_type = '0;
  logic s_last = 1'b0, s_eoi = 1'b0, s_valid = 1'b0, s_ready;
  logic [31:0] key, bdi;
  logic key_valid, key_ready, bdi_eot, bdi_eoi, bdi_valid, bdi_ready;
  logic [3:0] bdi_type;
`ifdef ASCON_FMT_ERR_EN
  logic err;
`endif

  always #5 clk = ~clk;

  ascon_bdi_formatter dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_type(s_type),
    .s_last(s_last), .s_eoi(s_eoi), .s_valid(s_valid), .s_ready(s_ready),
    .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .bdi(bdi), .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
    .bdi_valid(bdi_valid), .bdi_ready(bdi_ready)
`ifdef ASCON_FMT_ERR_EN
    , .err(err)
`endif
  );

  typedef struct packed {logic [31:0] d; logic [3:0] t; logic eot; logic eoi;} beat_t;
  beat_t bdi_exp[$];
  logic [31:0] key_exp[$];
  logic [7:0] bytes[$];
  beat_t cur, held;
  bit held_v = 0;
  int checks = 0, errors = 0;
  int bdi_mode = 0, key_mode = 0;
  logic [3:0] types [5] = '{D_KEY, D_NONCE, D_AD, D_MSG, D_TAG};

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // Reference: AD/MSG get 0x80 then zero fill to a word; empty AD/MSG emit nothing
  task automatic model(input logic [3:0] t, input bit eoi);
    logic [7:0] p[$];
    logic [31:0] w;
    bit l;
    p = bytes;
    if (t == D_AD || t == D_MSG) begin
      if (p.size() == 0) return;
      p.push_back(8'h80);
      while (p.size() % 4 != 0) p.push_back(8'h00);
    end
    for (int i = 0; i < p.size(); i += 4) begin
      w = {p[i], p[i+1], p[i+2], p[i+3]};
      l = (i + 4 >= p.size());
      if (t == D_KEY) key_exp.push_back(w);
      else bdi_exp.push_back({w, t, l, l & eoi});
    end
  endtask

  task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic [3:0] t, input bit l, input bit e);
    int tmo;
    s_data = d; s_keep = k; s_type = t; s_last = l; s_eoi = e; s_valid = 1'b1;
    @(negedge clk);
    tmo = 0;
    while (!s_ready && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_seg(input logic [3:0] t, input bit eoi);
    int n, nw;
    logic [31:0] w;
    logic [3:0] k;
    @(posedge clk);
    #1;
    model(t, eoi);
    n = bytes.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      k = 4'h0;
      for (int j = 0; j < 4; j++)
        if (4 * i + j < n) begin
          w[31-8*j -: 8] = bytes[4*i+j];
          k[3-j] = 1'b1;
        end
      drive_word(w, k, t, i == nw - 1, (i == nw - 1) && eoi);
    end
  endtask

  task automatic rand_bytes(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
  endtask

  task automatic drain();
    int tmo;
    bdi_mode = 0;
    key_mode = 0;
    tmo = 0;
    while ((bdi_exp.size() != 0 || key_exp.size() != 0) && tmo < 500) begin
      @(negedge clk);
      tmo++;
    end
    chk("drain_bdi", 64'(bdi_exp.size()), 64'd0);
    chk("drain_key", 64'(key_exp.size()), 64'd0);
  endtask

  task automatic chk_reset();
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_bdi_valid", 64'(bdi_valid), 64'd0);
    chk("rst_bdi_eot", 64'(bdi_eot), 64'd0);
    chk("rst_bdi_eoi", 64'(bdi_eoi), 64'd0);
    chk("rst_key", 64'(key), 64'd0);
    chk("rst_bdi", 64'(bdi), 64'd0);
    chk("rst_bdi_type", 64'(bdi_type), 64'(D_NULL));
    chk("rst_s_ready", 64'(s_ready), 64'd0);
`ifdef ASCON_FMT_ERR_EN
    chk("rst_err", 64'(err), 64'd0);
`endif
  endtask

  initial begin
    bdi_ready = 1'b0;
    key_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bdi_ready = bdi_mode == 0 ? 1'b1 : bdi_mode == 1 ? ~bdi_ready : bdi_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      key_ready = key_mode == 0 ? 1'b1 : key_mode == 1 ? ~key_ready : key_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) held_v = 0;
      else begin
        cur = {bdi, bdi_type, bdi_eot, bdi_eoi};
        if (bdi_valid) begin
          if (held_v) chk("bdi_stable", 64'(cur), 64'(held));
          if (bdi_ready) begin
            held_v = 0;
            if (bdi_exp.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_bdi: got %h type %h want none", bdi, bdi_type);
            end else chk("bdi_beat", 64'(cur), 64'(bdi_exp.pop_front()));
          end else begin
            held = cur;
            held_v = 1;
          end
        end else held_v = 0;
        if (key_valid && key_ready) begin
          if (key_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got %h want none", key);
          end else chk("key_word", 64'(key), 64'(key_exp.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst = 1'b1;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_seg(D_AD, 1'b0);
    @(negedge clk);
    chk("latency_valid", 64'(bdi_valid), 64'd1);
    chk("pad_s_ready_low", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("pad_s_ready_back", 64'(s_ready), 64'd1);
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_seg(D_MSG, 1'b1);
    rand_bytes(16);
    send_seg(D_NONCE, 1'b0);
    bytes.delete();
    send_seg(D_AD, 1'b0);
    rand_bytes(6);
    send_seg(D_MSG, 1'b1);
    drain();
    bdi_mode = 1;
    rand_bytes(16);
    send_seg(D_NONCE, 1'b1);
    drain();
    bdi_mode = 3;
    rand_bytes(16);
    send_seg(D_KEY, 1'b0);
    repeat (3) @(negedge clk);
    chk("key_while_bdi_stalled", 64'(key_exp.size()), 64'd0);
    chk("bdi_idle_during_key", 64'(bdi_valid), 64'd0);
    for (int s = 0; s < 40; s++) begin
      logic [3:0] t;
      t = types[$urandom_range(0, 4)];
      bdi_mode = $urandom_range(0, 2);
      key_mode = $urandom_range(0, 2);
      rand_bytes((t == D_AD || t == D_MSG) ? $urandom_range(0, 13) : 4 * $urandom_range(1, 4));
      send_seg(t, 1'($urandom_range(0, 1)));
    end
    drain();
`ifdef ASCON_FMT_ERR_EN
    @(negedge clk);
    chk("err_clean", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    key_exp.push_back(32'hAABBCCDD);
    drive_word(32'hAABBCCDD, 4'b1010, D_KEY, 1'b1, 1'b0);
    @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    drain();
`endif
    bdi_mode = 3;
    rand_bytes(4);
    send_seg(D_AD, 1'b1);
    @(negedge clk);
    chk("midpad_valid", 64'(bdi_valid), 64'd1);
    chk("midpad_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    bdi_exp.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset();
    rst = 1'b1;
    bdi_mode = 0;
    repeat (3) @(negedge clk);
    chk("no_pad_after_rst", 64'(bdi_valid), 64'd0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
